pixel_frame_sequencer: RTL and testbench

Programmable frame-timing controller for the pixel array. It replaces fixed counter-decode timing with a registered phase FSM that drives the pixel control lines (Vrst select, pixel reset, precharge, sample, memory select, pulse, row select) from host-written timing words. It sits between the host wire-in endpoints (config, start/stop) and the array pins, and reports status back through wire-out endpoints.

---
 rtl/pixel_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sequencer.sv
// Pixel-array frame timing controller: a registered phase FSM that drives the
// array control lines from host-programmed phase lengths latched per frame.
module pixel_frame_sequencer #(
    parameter int CW  = 10,
    parameter int RW  = 9,
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           continuous,
    input  logic           abort,
    input  logic [CW-1:0]  cfg_rst_len,
    input  logic [CW-1:0]  cfg_exposure,
    input  logic [CW-1:0]  cfg_pc_len,
    input  logic [CW-1:0]  cfg_sample_len,
    input  logic [CW-1:0]  cfg_row_len,
    input  logic [RW-1:0]  cfg_num_rows,
    output logic           vrst_sel,
    output logic           rst_pix,
    output logic           precharge,
    output logic           sample,
    output logic           mem_sel,
    output logic           pulse,
    output logic           row_select,
    output logic [RW-1:0]  row_addr,
    output logic           busy,
    output logic           frame_done,
    output logic [FCW-1:0] frame_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_RESET, S_SETTLE, S_EXPOSE,
        S_PRECHG, S_SAMPLE, S_HOLD, S_ROW, S_GAP
    } state_t;

    localparam logic [CW-1:0]  ONE_C = CW'(1);
    localparam logic [RW-1:0]  ONE_R = RW'(1);
    localparam logic [FCW-1:0] ONE_F = FCW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] row_nxt;
    logic          latch_cfg;
    logic          done_nxt;

    logic [CW-1:0] sh_rst, sh_exp, sh_pc, sh_smp, sh_row;
    logic [RW-1:0] sh_rows;

    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] v);
        return (v == '0) ? ONE_C : v;
    endfunction

    function automatic logic [RW-1:0] clamp_rows(input logic [RW-1:0] v);
        return (v == '0) ? ONE_R : v;
    endfunction

    // {vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}
    function automatic logic [6:0] decode(input state_t s);
        case (s)
            S_SETUP:  return 7'b0000100;
            S_RESET:  return 7'b0100100;
            S_SETTLE: return 7'b0000100;
            S_EXPOSE: return 7'b1000100;
            S_PRECHG: return 7'b1010100;
            S_SAMPLE: return 7'b1001100;
            S_HOLD:   return 7'b1000000;
            S_ROW:    return 7'b1000011;
            default:  return 7'b1000010;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row_addr;
        latch_cfg = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            row_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state_nxt = S_SETUP;
                    latch_cfg = 1'b1;
                end
                S_SETUP: begin
                    state_nxt = S_RESET;
                    cnt_nxt   = '0;
                end
                S_RESET: if (cnt == sh_rst - ONE_C) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + ONE_C;
                S_SETTLE: begin
                    state_nxt = S_EXPOSE;
                    cnt_nxt   = '0;
                end
                S_EXPOSE: if (cnt == sh_exp - ONE_C) begin
                    state_nxt = S_PRECHG;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + ONE_C;
                S_PRECHG: if (cnt == sh_pc - ONE_C) begin
                    state_nxt = S_SAMPLE;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + ONE_C;
                S_SAMPLE: if (cnt == sh_smp - ONE_C) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + ONE_C;
                S_HOLD: begin
                    state_nxt = S_ROW;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                end
                S_ROW: if (cnt == sh_row - ONE_C) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + ONE_C;
                S_GAP: begin
                    cnt_nxt = '0;
                    if (row_addr == sh_rows - ONE_R) begin
                        row_nxt = '0;
                        if (continuous) begin
                            state_nxt = S_SETUP;
                            latch_cfg = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        state_nxt = S_ROW;
                        row_nxt   = row_addr + ONE_R;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they align with the state register.
    assign done_nxt = (state_nxt == S_GAP) && (row_nxt == sh_rows - ONE_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            row_addr    <= '0;
            vrst_sel    <= 1'b1;
            rst_pix     <= 1'b0;
            precharge   <= 1'b0;
            sample      <= 1'b0;
            mem_sel     <= 1'b0;
            pulse       <= 1'b1;
            row_select  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            row_addr   <= row_nxt;
            {vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select} <= decode(state_nxt);
            busy       <= (state_nxt != S_IDLE);
            frame_done <= done_nxt;
            if (done_nxt) frame_count <= frame_count + ONE_F;
        end
    end

    // Shadow config: frozen for the whole frame so host writes take effect next frame.
    always_ff @(posedge clk) begin
        if (latch_cfg) begin
            sh_rst  <= clamp_len(cfg_rst_len);
            sh_exp  <= clamp_len(cfg_exposure);
            sh_pc   <= clamp_len(cfg_pc_len);
            sh_smp  <= clamp_len(cfg_sample_len);
            sh_row  <= clamp_len(cfg_row_len);
            sh_rows <= clamp_rows(cfg_num_rows);
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: per-cycle capture of control lines
// against hand-computed phase boundaries.
module tb_pixel_frame_sequencer;

    localparam int CW  = 10;
    localparam int RW  = 9;
    localparam int FCW = 16;
    localparam logic [6:0] IDLE_LINES = 7'b1000010;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic           abort = 1'b0;
    logic [CW-1:0]  cfg_rst_len = '0;
    logic [CW-1:0]  cfg_exposure = '0;
    logic [CW-1:0]  cfg_pc_len = '0;
    logic [CW-1:0]  cfg_sample_len = '0;
    logic [CW-1:0]  cfg_row_len = '0;
    logic [RW-1:0]  cfg_num_rows = '0;
    logic           vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select;
    logic [RW-1:0]  row_addr;
    logic           busy, frame_done;
    logic [FCW-1:0] frame_count;

    pixel_frame_sequencer #(.CW(CW), .RW(RW), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
        .cfg_rst_len(cfg_rst_len), .cfg_exposure(cfg_exposure), .cfg_pc_len(cfg_pc_len),
        .cfg_sample_len(cfg_sample_len), .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
        .vrst_sel(vrst_sel), .rst_pix(rst_pix), .precharge(precharge), .sample(sample),
        .mem_sel(mem_sel), .pulse(pulse), .row_select(row_select), .row_addr(row_addr),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    int busy_cyc, rp_first, rp_last, pc_first, pc_last, sm_first, sm_last;
    int fd_cnt, overlap;
    int rs_cnt[4];
    int fd_cyc[4];

    // Starts a frame and records per-cycle line activity until busy drops.
    task automatic capture(input int drop_at, input int chg_at, input int abort_at);
        int c;
        bit done;
        busy_cyc = 0; rp_first = 0; rp_last = 0; pc_first = 0; pc_last = 0;
        sm_first = 0; sm_last = 0; fd_cnt = 0; overlap = 0;
        for (int i = 0; i < 4; i++) begin rs_cnt[i] = 0; fd_cyc[i] = 0; end
        start = 1'b1;
        c = 0;
        done = 1'b0;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            abort = 1'b0;
            if (!busy) begin
                busy_cyc = c - 1;
                done = 1'b1;
            end else begin
                if (rst_pix)   begin if (rp_first == 0) rp_first = c; rp_last = c; end
                if (precharge) begin if (pc_first == 0) pc_first = c; pc_last = c; end
                if (sample)    begin if (sm_first == 0) sm_first = c; sm_last = c; end
                if (row_select && row_addr < 4) rs_cnt[row_addr]++;
                if (int'(precharge) + int'(sample) + int'(row_select) > 1) overlap++;
                if (frame_done) begin
                    if (fd_cnt < 4) fd_cyc[fd_cnt] = c;
                    fd_cnt++;
                end
                if (c == drop_at)  continuous = 1'b0;
                if (c == chg_at)   cfg_exposure = 10'd20;
                if (c == abort_at) abort = 1'b1;
            end
        end
        if (!done) check_val("capture_timeout", 1, 0);
    endtask

    task automatic set_cfg(input int rl, input int ex, input int pc, input int sm, input int rw, input int nr);
        cfg_rst_len    = CW'(rl);
        cfg_exposure   = CW'(ex);
        cfg_pc_len     = CW'(pc);
        cfg_sample_len = CW'(sm);
        cfg_row_len    = CW'(rw);
        cfg_num_rows   = RW'(nr);
    endtask

    initial begin
        #12;
        check_val("rst_lines", {25'd0, vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}, {25'd0, IDLE_LINES});
        check_val("rst_busy", {31'd0, busy}, 0);
        check_val("rst_fcount", {16'd0, frame_count}, 0);
        check_val("rst_row_addr", {23'd0, row_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single nominal frame
        set_cfg(9, 90, 10, 10, 4, 3);
        capture(0, 0, 0);
        check_val("single_busy", busy_cyc, 137);
        check_val("single_rp_first", rp_first, 2);
        check_val("single_rp_last", rp_last, 10);
        check_val("single_pc_first", pc_first, 102);
        check_val("single_pc_last", pc_last, 111);
        check_val("single_sm_first", sm_first, 112);
        check_val("single_sm_last", sm_last, 121);
        check_val("single_row0", rs_cnt[0], 4);
        check_val("single_row1", rs_cnt[1], 4);
        check_val("single_row2", rs_cnt[2], 4);
        check_val("single_overlap", overlap, 0);
        check_val("single_fd_cnt", fd_cnt, 1);
        check_val("single_fd_cyc", fd_cyc[0], 137);
        check_val("single_fcount", {16'd0, frame_count}, 1);
        check_val("single_idle_lines", {25'd0, vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}, {25'd0, IDLE_LINES});

        // Continuous: three back-to-back frames, continuous dropped during the third
        continuous = 1'b1;
        capture(300, 0, 0);
        check_val("cont_busy", busy_cyc, 411);
        check_val("cont_fd_cnt", fd_cnt, 3);
        check_val("cont_fd0", fd_cyc[0], 137);
        check_val("cont_fd1", fd_cyc[1], 274);
        check_val("cont_fd2", fd_cyc[2], 411);
        check_val("cont_fcount", {16'd0, frame_count}, 4);
        check_val("cont_flag", {31'd0, continuous}, 0);

        // All-zero config clamps every length and the row count to 1
        set_cfg(0, 0, 0, 0, 0, 0);
        capture(0, 0, 0);
        check_val("zero_busy", busy_cyc, 9);
        check_val("zero_rp_first", rp_first, 2);
        check_val("zero_rp_last", rp_last, 2);
        check_val("zero_pc_first", pc_first, 5);
        check_val("zero_sm_first", sm_first, 6);
        check_val("zero_row0", rs_cnt[0], 1);
        check_val("zero_row1", rs_cnt[1], 0);
        check_val("zero_fd_cyc", fd_cyc[0], 9);
        check_val("zero_fcount", {16'd0, frame_count}, 5);

        // Exposure rewritten mid-frame only affects the following frame
        set_cfg(9, 90, 10, 10, 4, 3);
        capture(0, 50, 0);
        check_val("chg_cur_pc_first", pc_first, 102);
        check_val("chg_cur_busy", busy_cyc, 137);
        capture(0, 0, 0);
        check_val("chg_next_pc_first", pc_first, 32);
        check_val("chg_next_busy", busy_cyc, 67);
        check_val("chg_fcount", {16'd0, frame_count}, 7);

        // Abort in the second cycle of row 1
        set_cfg(9, 90, 10, 10, 4, 3);
        capture(0, 0, 129);
        check_val("abort_busy", busy_cyc, 129);
        check_val("abort_row0", rs_cnt[0], 4);
        check_val("abort_row1", rs_cnt[1], 2);
        check_val("abort_fd_cnt", fd_cnt, 0);
        check_val("abort_fcount", {16'd0, frame_count}, 7);
        check_val("abort_row_select", {31'd0, row_select}, 0);
        check_val("abort_row_addr", {23'd0, row_addr}, 0);
        check_val("abort_lines", {25'd0, vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}, {25'd0, IDLE_LINES});
        capture(0, 0, 0);
        check_val("post_abort_busy", busy_cyc, 137);
        check_val("post_abort_fcount", {16'd0, frame_count}, 8);

        // Asynchronous reset in the middle of EXPOSE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_val("mid_expose_lines", {25'd0, vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}, {25'd0, 7'b1000100});
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_lines", {25'd0, vrst_sel, rst_pix, precharge, sample, mem_sel, pulse, row_select}, {25'd0, IDLE_LINES});
        check_val("async_rst_busy", {31'd0, busy}, 0);
        check_val("async_rst_fcount", {16'd0, frame_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("after_rst_busy", {31'd0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
